// File: rtl/oam_update_ctrl.sv
// OAM write-side controller: queues sprite commands and applies them to OAM RAM during vblank.
// Optional build macro OAM_CLAMP_EN: MOVE saturates at screen bounds instead of wrapping.
module oam_update_ctrl #(
   parameter int unsigned OAM_DEPTH  = 8,
   parameter int unsigned ADDR_W     = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SCREEN_W   = 640,
   parameter int unsigned SCREEN_H   = 480,
   parameter int unsigned TILE       = 32,
   parameter int unsigned STEP       = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vblank,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_idx,
   input  logic [30:0]       cmd_arg,
   output logic [ADDR_W-1:0] oam_raddr,
   input  logic [31:0]       oam_rdata,
   output logic              oam_we,
   output logic [ADDR_W-1:0] oam_waddr,
   output logic [31:0]       oam_wdata,
   output logic              busy
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [10:0] STEP11 = 11'(STEP);
`ifdef OAM_CLAMP_EN
   localparam logic [10:0] X_MAX = 11'(SCREEN_W - TILE);
   localparam logic [10:0] Y_MAX = 11'(SCREEN_H - TILE);
`endif

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_MOVE  = 2'b01;
   localparam logic [1:0] OP_EN    = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef struct packed {
      logic [1:0]        op;
      logic [ADDR_W-1:0] idx;
      logic [30:0]       arg;
   } cmd_t;

   typedef enum logic [2:0] {StIdle, StRead, StModify, StWrite, StClear} state_e;

   cmd_t              fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
   logic              full, empty, push, pop;
   cmd_t              head;

   state_e            state_q, state_d;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] idx_q;
   logic [1:0]        arg_q;
   logic [ADDR_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       mod_word;
   logic [10:0]       pos, pos_new;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = (state_q == StIdle) && vblank && !empty;
   assign head      = fifo_mem[rd_ptr_q[PTR_W-1:0]];

   assign oam_raddr = raddr_q;
   assign oam_waddr = waddr_q;
   assign oam_wdata = wdata_q;
   assign oam_we    = (state_q == StWrite) || (state_q == StClear);
   assign busy      = (state_q != StIdle) || !empty;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= '{op: cmd_op, idx: cmd_idx, arg: cmd_arg};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         state_q  <= StIdle;
         op_q     <= '0;
         idx_q    <= '0;
         arg_q    <= '0;
         raddr_q  <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         state_q <= state_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         if (push) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            op_q     <= head.op;
            idx_q    <= head.idx;
            arg_q    <= head.arg[1:0];
         end
      end
   end

   // Read-modify-write datapath; position math is 11 bits so under/overflow is visible.
   always_comb begin
      mod_word     = oam_rdata;
      mod_word[31] = 1'b0;
      pos          = arg_q[1] ? {1'b0, oam_rdata[27:18]} : {1'b0, oam_rdata[17:8]};
      pos_new      = arg_q[0] ? pos + STEP11 : pos - STEP11;
`ifdef OAM_CLAMP_EN
      if (arg_q[0] ? (pos_new > (arg_q[1] ? X_MAX : Y_MAX)) : (pos < STEP11)) pos_new = pos;
`endif
      if (op_q == OP_EN) begin
         mod_word[28] = arg_q[0];
      end else begin
         mod_word[7:6] = arg_q;
         mod_word[2:0] = {1'b0, arg_q};
         if (arg_q[1]) mod_word[27:18] = pos_new[9:0];
         else          mod_word[17:8]  = pos_new[9:0];
      end
   end

   always_comb begin
      state_d = state_q;
      raddr_d = raddr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               unique case (head.op)
                  OP_WRITE: begin
                     state_d = StWrite;
                     waddr_d = head.idx;
                     wdata_d = {1'b0, head.arg};
                  end
                  OP_MOVE, OP_EN: begin
                     state_d = StRead;
                     raddr_d = head.idx;
                  end
                  OP_CLEAR: begin
                     state_d = StClear;
                     waddr_d = '0;
                     wdata_d = '0;
                  end
                  default: state_d = StIdle;
               endcase
            end
         end
         StRead:   state_d = StModify;
         StModify: begin
            state_d = StWrite;
            waddr_d = idx_q;
            wdata_d = mod_word;
         end
         StWrite:  state_d = StIdle;
         // Runs to the last entry regardless of vblank.
         StClear: begin
            if (waddr_q == ADDR_W'(OAM_DEPTH - 1)) state_d = StIdle;
            else                                   waddr_d = waddr_q + ADDR_W'(1);
         end
         default:  state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_oam_update_ctrl.sv
// Bench for oam_update_ctrl: directed timing scenarios plus random traffic against an
// in-order OAM content model and expected-write scoreboard.
module tb_oam_update_ctrl;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int TILE     = 32;
   localparam int STEP     = 1;

   logic        clk = 1'b0;
   logic        rst, vblank, cmd_valid, cmd_ready, oam_we, busy;
   logic [1:0]  cmd_op;
   logic [2:0]  cmd_idx, oam_raddr, oam_waddr;
   logic [30:0] cmd_arg;
   logic [31:0] oam_rdata, oam_wdata;

   always #5 clk = ~clk;

   oam_update_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .vblank    (vblank),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_idx   (cmd_idx),
      .cmd_arg   (cmd_arg),
      .oam_raddr (oam_raddr),
      .oam_rdata (oam_rdata),
      .oam_we    (oam_we),
      .oam_waddr (oam_waddr),
      .oam_wdata (oam_wdata),
      .busy      (busy)
   );

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic [31:0] ram       [8] = '{default: 32'h0};
   logic [31:0] model_mem [8] = '{default: 32'h0};
   logic [31:0] snapshot  [8];
   wr_t         exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          wr_count = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Synchronous-read RAM seen by the DUT.
   always @(posedge clk) begin
      if (oam_we) ram[oam_waddr] <= oam_wdata;
      oam_rdata <= ram[oam_raddr];
   end

   always @(negedge clk) begin
      if (oam_we) begin
         wr_t e;
         wr_count++;
         if (exp_q.size() == 0) begin
            check("spurious_we", 32'(oam_waddr), 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            check("we_addr", 32'(oam_waddr), 32'(e.addr));
            check("we_data", oam_wdata, e.data);
         end
      end
   end

   function automatic logic [31:0] model_move(input logic [31:0] w, input logic [1:0] dir);
      int x  = int'(w[27:18]);
      int y  = int'(w[17:8]);
      int nx = x;
      int ny = y;
      case (dir)
         2'd0: ny = y - STEP;
         2'd1: ny = y + STEP;
         2'd2: nx = x - STEP;
         default: nx = x + STEP;
      endcase
`ifdef OAM_CLAMP_EN
      if (nx < 0 || (nx > x && nx > SCREEN_W - TILE)) nx = x;
      if (ny < 0 || (ny > y && ny > SCREEN_H - TILE)) ny = y;
`else
      nx = (nx + 1024) % 1024;
      ny = (ny + 1024) % 1024;
`endif
      return {1'b0, w[30:29], w[28], nx[9:0], ny[9:0], dir, w[5:3], 1'b0, dir};
   endfunction

   // Commands take effect in acceptance order, so the model applies them immediately.
   task automatic model_accept(input logic [1:0] op, input logic [2:0] idx, input logic [30:0] arg);
      logic [31:0] w;
      case (op)
         2'd0: begin
            model_mem[idx] = {1'b0, arg};
            exp_q.push_back('{addr: idx, data: {1'b0, arg}});
         end
         2'd1: begin
            model_mem[idx] = model_move(model_mem[idx], arg[1:0]);
            exp_q.push_back('{addr: idx, data: model_mem[idx]});
         end
         2'd2: begin
            w = model_mem[idx];
            w[28] = arg[0];
            w[31] = 1'b0;
            model_mem[idx] = w;
            exp_q.push_back('{addr: idx, data: w});
         end
         default: begin
            for (int i = 0; i < 8; i++) begin
               model_mem[i] = 32'h0;
               exp_q.push_back('{addr: 3'(i), data: 32'h0});
            end
         end
      endcase
   endtask

   // Returns 1ns after the clock edge at which the command was offered.
   task automatic push(input logic [1:0] op, input logic [2:0] idx, input logic [30:0] arg,
                       output bit acc);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_idx   = idx;
      cmd_arg   = arg;
      acc       = cmd_ready;
      if (acc) model_accept(op, idx, arg);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      bit done = 0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1;
      end
      check("idle_reached", 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int wc;
      rst = 1'b1; vblank = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_arg = '0;
      repeat (3) @(negedge clk);
      check("rst_we", 32'(oam_we), 32'd0);
      check("rst_raddr", 32'(oam_raddr), 32'd0);
      check("rst_waddr", 32'(oam_waddr), 32'd0);
      check("rst_wdata", oam_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b0;
      vblank = 1'b1;

      // Plain WRITE: single strobe one cycle after the pop cycle.
      push(2'd0, 3'd2, 31'h1004_0A03, acc);
      @(negedge clk);
      check("w_n_we", 32'(oam_we), 32'd0);
      @(negedge clk);
      check("w_n1_we", 32'(oam_we), 32'd1);
      check("w_n1_addr", 32'(oam_waddr), 32'd2);
      check("w_n1_data", oam_wdata, 32'h1004_0A03);
      @(negedge clk);
      check("w_n2_we", 32'(oam_we), 32'd0);
      wait_idle(20);

      // MOVE right from x=100 y=50.
      push(2'd0, 3'd1, {2'b01, 1'b1, 10'd100, 10'd50, 2'b00, 3'd5, 3'd0}, acc);
      wait_idle(20);
      push(2'd1, 3'd1, 31'd3, acc);
      @(negedge clk);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("mv_n%0d_we", c), 32'(oam_we), (c == 3) ? 32'd1 : 32'd0);
         if (c == 3) begin
            check("mv_addr", 32'(oam_waddr), 32'd1);
            check("mv_data", oam_wdata, {1'b0, 2'b01, 1'b1, 10'd101, 10'd50, 2'b11, 3'd5, 3'd3});
         end
      end
      check("mv_busy_after", 32'(busy), 32'd0);

      // Commands held while vblank is low, then drained in order.
      vblank = 1'b0;
      wc = wr_count;
      for (int i = 0; i < 4; i++) push(2'd0, 3'(i + 4), 31'(32'h0111_0000 * (i + 1)), acc);
      @(negedge clk);
      check("full_ready", 32'(cmd_ready), 32'd0);
      push(2'd0, 3'd0, 31'h7fff_ffff, acc);
      check("full_not_acc", 32'(acc), 32'd0);
      repeat (5) @(negedge clk);
      check("no_write_active", 32'(wr_count - wc), 32'd0);
      vblank = 1'b1;
      @(negedge clk);
      check("ready_after_pop", 32'(cmd_ready), 32'd1);
      wait_idle(40);
      check("drain_writes", 32'(wr_count - wc), 32'd4);

      // CLEAR_ALL continues after vblank drops.
      push(2'd3, 3'd0, 31'd0, acc);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("clr_we", 32'(oam_we), 32'd1);
         check("clr_addr", 32'(oam_waddr), 32'(i));
         if (i == 2) vblank = 1'b0;
      end
      @(negedge clk);
      check("clr_end_we", 32'(oam_we), 32'd0);
      vblank = 1'b1;
      wait_idle(20);

      // Left edge behaviour.
      push(2'd0, 3'd3, {2'b00, 1'b1, 10'd0, 10'd200, 2'b00, 3'd0, 3'd0}, acc);
      push(2'd1, 3'd3, 31'd2, acc);
      wait_idle(40);
`ifdef OAM_CLAMP_EN
      check("edge_x", 32'(ram[3][27:18]), 32'd0);
`else
      check("edge_x", 32'(ram[3][27:18]), 32'd1023);
`endif

      // Reset in the middle of a read-modify-write.
      push(2'd0, 3'd4, 31'h0320_1400, acc);
      wait_idle(20);
      snapshot = model_mem;
      push(2'd1, 3'd4, 31'd3, acc);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_we", 32'(oam_we), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_ready", 32'(cmd_ready), 32'd1);
      exp_q.delete();
      model_mem = snapshot;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_mid_no_we", 32'(oam_we), 32'd0);
      check("rst_mid_ram", ram[4], 32'h0320_1400);

      // Random traffic.
      for (int it = 0; it < 500; it++) begin
         if ($urandom_range(0, 7) == 0) vblank = ~vblank;
         if ($urandom_range(0, 1) == 1) begin
            logic [1:0] op;
            int sel = $urandom_range(0, 19);
            op = (sel < 6) ? 2'd0 : (sel < 14) ? 2'd1 : (sel < 19) ? 2'd2 : 2'd3;
            push(op, 3'($urandom_range(0, 7)), 31'($urandom), acc);
         end else begin
            @(posedge clk);
            #1;
         end
      end
      vblank = 1'b1;
      wait_idle(200);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 8; i++) check($sformatf("final_mem%0d", i), ram[i], model_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
